mult_div_unit: RTL and testbench

- Multi-cycle multiply/divide unit with HI/LO registers for the pipelined MIPS CPU (`mips`).
- Sits in the EX stage beside the ALU. It consumes the forwarded rs/rt operands and a one-cycle start pulse from EX.
- It drives HI/LO to the EX result mux for MFHI/MFLO and drives `busy` to the hazard unit, which stalls MD-class instructions in ID.
- Latencies model a realistic iterative multiplier and divider.

---
 rtl/mult_div_unit.sv | 131 +++++++++++++
 tb/tb_mult_div_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage of the MIPS pipeline.
// Operands are latched on start; HI/LO are written on the final busy cycle.
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  logic            busy_q, busy_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;

  logic        is_signed, is_div, res_we;
  logic [63:0] ext_a, ext_b, prod;
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b, q_mag, r_mag, quot, rem;
  logic [31:0] res_hi, res_lo;

  // Result datapath works only from the latched operands.
  always_comb begin
    is_signed = (op_q == OpMult) || (op_q == OpDiv);
    is_div    = (op_q == OpDiv) || (op_q == OpDivu);

    ext_a = is_signed ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
    ext_b = is_signed ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
    prod  = ext_a * ext_b;

    // Divide on magnitudes so INT_MIN / -1 wraps instead of overflowing.
    neg_a = is_signed && a_q[31];
    neg_b = is_signed && b_q[31];
    mag_a = neg_a ? -a_q : a_q;
    mag_b = neg_b ? -b_q : b_q;
    q_mag = (mag_b == 32'd0) ? 32'd0 : mag_a / mag_b;
    r_mag = (mag_b == 32'd0) ? 32'd0 : mag_a % mag_b;
    quot  = (neg_a ^ neg_b) ? -q_mag : q_mag;
    rem   = neg_a ? -r_mag : r_mag;

    res_hi = is_div ? rem  : prod[63:32];
    res_lo = is_div ? quot : prod[31:0];
    res_we = !is_div || (b_q != 32'd0);
  end

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    op_d   = op_q;
    a_d    = a_q;
    b_d    = b_q;
    hi_d   = hi_q;
    lo_d   = lo_q;

    if (busy_q) begin
      cnt_d = cnt_q - CntW'(1);
      if (cnt_q == CntW'(1)) begin
        busy_d = 1'b0;
        if (res_we) begin
          hi_d = res_hi;
          lo_d = res_lo;
        end
      end
    end else if (start) begin
      unique case (md_op)
        OpMult, OpMultu: begin
          busy_d = 1'b1;
          cnt_d  = CntW'(MULT_CYCLES);
          op_d   = md_op;
          a_d    = src_a;
          b_d    = src_b;
        end
        OpDiv, OpDivu: begin
          busy_d = 1'b1;
          cnt_d  = CntW'(DIV_CYCLES);
          op_d   = md_op;
          a_d    = src_a;
          b_d    = src_b;
        end
        OpMthi:  hi_d = src_a;
        OpMtlo:  lo_d = src_a;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      a_q    <= a_d;
      b_q    <= b_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed scenarios plus randomized ops against a
// plain-arithmetic model of HI/LO.
module tb_mult_div_unit;

  localparam int unsigned MultN = 5;
  localparam int unsigned DivN  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        busy;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] ref_hi = 32'd0;
  logic [31:0] ref_lo = 32'd0;

  mult_div_unit #(
    .MULT_CYCLES(MultN),
    .DIV_CYCLES (DivN)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .md_op(md_op),
    .src_a(src_a),
    .src_b(src_b),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  // Architectural model of HI/LO after an accepted operation.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd1: begin sq = sa * sb; ref_hi = sq[63:32]; ref_lo = sq[31:0]; end
      3'd2: begin up = {32'd0, a} * {32'd0, b}; ref_hi = up[63:32]; ref_lo = up[31:0]; end
      3'd3: if (b != 0) begin
        sq = sa / sb; sr = sa % sb; ref_lo = sq[31:0]; ref_hi = sr[31:0];
      end
      3'd4: if (b != 0) begin ref_lo = a / b; ref_hi = a % b; end
      3'd5: ref_hi = a;
      3'd6: ref_lo = a;
      default: ;
    endcase
  endtask

  function automatic int exp_cycles(input logic [2:0] op);
    if (op == 3'd1 || op == 3'd2) return MultN;
    if (op == 3'd3 || op == 3'd4) return DivN;
    return 0;
  endfunction

  // Present one start for one edge; returns at the negedge after that edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; md_op = op; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0; md_op = 3'd0;
    model(op, a, b);
  endtask

  // Counts negedges with busy high; bounded so a stuck busy cannot hang the run.
  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0)
      $display("FAIL reset: busy=%b hi=%h lo=%h required 0/0/0", busy, hi, lo);
    else n_pass++;
    ref_hi = 0; ref_lo = 0;
  endtask

  task automatic test_mult();
    int c;
    issue(3'd1, 32'hFFFFFFFD, 32'd5);
    wait_idle(c);
    n_checks++;
    if (c !== MultN) $display("FAIL mult_busy: got %0d cycles required %0d", c, MultN);
    else n_pass++;
    n_checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1)
      $display("FAIL mult_neg: got %h_%h required ffffffff_fffffff1", hi, lo);
    else n_pass++;

    issue(3'd2, 32'hFFFFFFFF, 32'd2);
    wait_idle(c);
    n_checks++;
    if (hi !== 32'h00000001 || lo !== 32'hFFFFFFFE)
      $display("FAIL multu: got %h_%h required 00000001_fffffffe", hi, lo);
    else n_pass++;

    issue(3'd1, 32'hFFFFFFFF, 32'd2);
    wait_idle(c);
    n_checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFE)
      $display("FAIL mult_signed: got %h_%h required ffffffff_fffffffe", hi, lo);
    else n_pass++;
  endtask

  task automatic test_div();
    int c;
    issue(3'd3, 32'hFFFFFFF9, 32'd2);
    wait_idle(c);
    n_checks++;
    if (c !== DivN) $display("FAIL div_busy: got %0d cycles required %0d", c, DivN);
    else n_pass++;
    n_checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD)
      $display("FAIL div_neg: got hi=%h lo=%h required ffffffff/fffffffd", hi, lo);
    else n_pass++;

    issue(3'd4, 32'd7, 32'd2);
    wait_idle(c);
    n_checks++;
    if (hi !== 32'd1 || lo !== 32'd3)
      $display("FAIL divu: got hi=%h lo=%h required 1/3", hi, lo);
    else n_pass++;

    issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(c);
    n_checks++;
    if (hi !== 32'd0 || lo !== 32'h80000000)
      $display("FAIL div_wrap: got hi=%h lo=%h required 0/80000000", hi, lo);
    else n_pass++;
  endtask

  task automatic test_mthi_mtlo_divzero();
    int c;
    issue(3'd5, 32'h12345678, 32'd0);
    n_checks++;
    if (hi !== 32'h12345678 || busy !== 1'b0)
      $display("FAIL mthi: got hi=%h busy=%b required 12345678/0", hi, busy);
    else n_pass++;
    issue(3'd6, 32'h9ABCDEF0, 32'd0);
    n_checks++;
    if (lo !== 32'h9ABCDEF0 || busy !== 1'b0)
      $display("FAIL mtlo: got lo=%h busy=%b required 9abcdef0/0", lo, busy);
    else n_pass++;

    issue(3'd4, 32'd7, 32'd0);
    wait_idle(c);
    n_checks++;
    if (c !== DivN) $display("FAIL divzero_busy: got %0d cycles required %0d", c, DivN);
    else n_pass++;
    n_checks++;
    if (hi !== 32'h12345678 || lo !== 32'h9ABCDEF0)
      $display("FAIL divzero_keep: got hi=%h lo=%h required 12345678/9abcdef0", hi, lo);
    else n_pass++;
  endtask

  task automatic test_busy_ignore_back_to_back();
    int c;
    issue(3'd3, 32'hFFFFFFF9, 32'd2);  // busy cycle 1 now
    @(negedge clk);                    // cycle 2
    start = 1'b1; md_op = 3'd6; src_a = 32'hDEADBEEF; src_b = 32'd1;
    @(negedge clk);                    // sampled while busy
    start = 1'b0; md_op = 3'd0; src_a = 32'h55555555; src_b = 32'd3;
    wait_idle(c);
    n_checks++;
    if (c + 2 !== DivN) $display("FAIL ignore_busy: got %0d cycles required %0d", c + 2, DivN);
    else n_pass++;
    n_checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD)
      $display("FAIL ignore_result: got hi=%h lo=%h required ffffffff/fffffffd", hi, lo);
    else n_pass++;

    // Completion cycle: issue immediately.
    issue(3'd1, 32'd3, 32'd7);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL b2b_accept: got busy=%b required 1", busy);
    else n_pass++;
    wait_idle(c);
    issue(3'd5, 32'hCAFEF00D, 32'd0);
    n_checks++;
    if (hi !== 32'hCAFEF00D || lo !== 32'd21)
      $display("FAIL b2b_mthi: got hi=%h lo=%h required cafef00d/00000015", hi, lo);
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    bit seen16 = 0;
    issue(3'd1, 32'd4, 32'd4);  // busy cycle 1
    @(negedge clk);             // cycle 2
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0)
      $display("FAIL reset_abort: busy=%b hi=%h lo=%h required 0/0/0", busy, hi, lo);
    else n_pass++;
    repeat (MultN + 3) begin
      @(negedge clk);
      if (lo === 32'd16 || busy !== 1'b0) seen16 = 1;
    end
    n_checks++;
    if (seen16) $display("FAIL reset_late_write: got lo=%h busy=%b required no write-back", lo, busy);
    else n_pass++;
    ref_hi = 0; ref_lo = 0;
  endtask

  task automatic test_random();
    int c;
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9)) * ($urandom_range(0, 1) ? 1 : -1);
      issue(op, a, b);
      wait_idle(c);
      n_checks++;
      if (c !== exp_cycles(op) || hi !== ref_hi || lo !== ref_lo)
        $display("FAIL random[%0d] op=%0d a=%h b=%h: got %0d cy hi=%h lo=%h required %0d cy hi=%h lo=%h",
                 i, op, a, b, c, hi, lo, exp_cycles(op), ref_hi, ref_lo);
      else n_pass++;
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo_divzero();
    test_busy_ignore_back_to_back();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
